// File: rtl/audio_dsp_pkg.sv
// audio_dsp_pkg: shared audio DSP constants, low-pass coefficients, saturation helper and FSM states
package audio_dsp_pkg;

    localparam int SAMPLE_WIDTH = 16;

    // Q1.15 low-pass taps for a 4x interpolator. Each polyphase branch sums to 8192 (0.25),
    // so the x4 post-filter gain gives unity DC. Negative side lobes give a real overshoot.
    localparam logic signed [15:0] LP16 [16] = '{
        -16'sd300, -16'sd500, -16'sd400,  16'sd300,  16'sd1800, 16'sd3700, 16'sd5392, 16'sd6392,
         16'sd6392, 16'sd5392, 16'sd3700, 16'sd1800, 16'sd300, -16'sd400, -16'sd500, -16'sd300
    };

    localparam logic signed [15:0] LP8 [8] = '{
        16'sd1000, 16'sd2500, 16'sd5692, 16'sd7192, 16'sd7192, 16'sd5692, 16'sd2500, 16'sd1000
    };

    typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_t;

    // Coefficient k for a filter of the given length; lengths without a table fall back to a boxcar
    // whose polyphase branches still sum to 1/INT_FACTOR of full scale.
    function automatic logic signed [15:0] lp_coef(input int taps, input int k);
        return taps == 16 ? LP16[k[3:0]] : taps == 8 ? LP8[k[2:0]] : 16'(32768 / taps);
    endfunction

    // Clamp a wide signed value into the 16-bit sample range.
    function automatic logic signed [SAMPLE_WIDTH-1:0] sat16(input logic signed [63:0] v);
        return v > 64'sd32767 ? 16'sh7fff : v < -64'sd32768 ? 16'sh8000 : v[15:0];
    endfunction

endpackage

// File: rtl/fir_mac_serial.sv
// fir_mac_serial: FIR delay line with a one-tap-per-cycle multiply-accumulate
module fir_mac_serial
    import audio_dsp_pkg::*;
#(
    parameter int NUM_TAPS   = 16,
    parameter int COEF_WIDTH = 16,
    parameter int ACC_W      = 36
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           start,
    input  logic signed [SAMPLE_WIDTH-1:0] shift_in,
    output logic                           last,
    output logic signed [ACC_W-1:0]        acc_sum
);
    localparam int IW = $clog2(NUM_TAPS);
    localparam int PW = SAMPLE_WIDTH + COEF_WIDTH;

    logic signed [SAMPLE_WIDTH-1:0] x [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0]   h [NUM_TAPS];
    logic [IW-1:0]                  idx;
    logic                           busy;
    logic signed [ACC_W-1:0]        acc;
    logic signed [PW-1:0]           prod;

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_coef
        assign h[k] = COEF_WIDTH'(lp_coef(NUM_TAPS, k));
    end

    assign prod    = PW'(x[idx]) * PW'(h[idx]);
    assign acc_sum = acc + ACC_W'(prod);
    assign last    = busy && idx == IW'(NUM_TAPS - 1);

    // start shifts the delay line and clears the sum; then one tap is accumulated per cycle
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x    <= '{default: '0};
            idx  <= '0;
            acc  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            x[0] <= shift_in;
            for (int k = 1; k < NUM_TAPS; k++) x[k] <= x[k-1];
            idx  <= '0;
            acc  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            acc  <= acc_sum;
            idx  <= idx + 1'b1;
            busy <= !last;
        end
    end

endmodule

// File: rtl/fir_interpolator.sv
// fir_interpolator: zero-stuffing upsampler with a serial-MAC low-pass FIR and saturating output
module fir_interpolator
    import audio_dsp_pkg::*;
#(
    parameter int INT_FACTOR = 4,
    parameter int NUM_TAPS   = 16,
    parameter int COEF_WIDTH = 16,
    parameter int COEF_FRAC  = 15
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic signed [SAMPLE_WIDTH-1:0] audio_in,
    input  logic                           audio_in_valid,
    output logic                           audio_in_ready,
    input  logic                           out_tick,
    output logic signed [SAMPLE_WIDTH-1:0] interp_output,
    output logic                           interp_output_valid,
    output logic                           overrun,
    output logic                           underrun
);
    localparam int GAIN_SH = $clog2(INT_FACTOR);
    localparam int ACC_W   = SAMPLE_WIDTH + COEF_WIDTH + $clog2(NUM_TAPS);

    fir_state_t                     state, state_nxt;
    logic [GAIN_SH-1:0]             phase;
    logic signed [SAMPLE_WIDTH-1:0] buf_data, shift_in;
    logic                           buf_full, fill, accept, take, mac_last;
    logic signed [ACC_W-1:0]        acc_sum;
    logic signed [63:0]             acc_ext, scaled;

    assign audio_in_ready = !buf_full;
    assign fill     = audio_in_valid && !buf_full;
    assign take     = accept && phase == '0 && buf_full;
    assign shift_in = take ? buf_data : '0;
    assign acc_ext  = {{(64-ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
    assign scaled   = ((acc_ext <<< GAIN_SH) + (64'sd1 <<< (COEF_FRAC - 1))) >>> COEF_FRAC;

    fir_mac_serial #(
        .NUM_TAPS  (NUM_TAPS),
        .COEF_WIDTH(COEF_WIDTH),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .start   (accept),
        .shift_in(shift_in),
        .last    (mac_last),
        .acc_sum (acc_sum)
    );

    // Next state: a tick in IDLE starts a computation, the final tap moves to OUT, OUT lasts one cycle
    always_comb begin
        accept    = out_tick && state == IDLE;
        state_nxt = state == IDLE ? (out_tick ? MAC : IDLE) : state == MAC ? (mac_last ? OUT : MAC) : IDLE;
    end

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // Input buffer, phase counter, status pulses and the rounded, saturated output register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            buf_data            <= '0;
            buf_full            <= 1'b0;
            phase               <= '0;
            interp_output       <= '0;
            interp_output_valid <= 1'b0;
            overrun             <= 1'b0;
            underrun            <= 1'b0;
        end else begin
            buf_full            <= fill || (buf_full && !take);
            if (fill) buf_data  <= audio_in;
            if (accept) phase   <= phase + 1'b1;
            overrun             <= out_tick && state != IDLE;
            underrun            <= accept && phase == '0 && !buf_full;
            interp_output_valid <= mac_last;
            if (mac_last) interp_output <= sat16(scaled);
        end
    end

endmodule

// File: tb/tb_fir_interpolator.sv
// tb_fir_interpolator: directed and random checks of the interpolator against a queue-based model
module tb_fir_interpolator;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic signed [15:0] audio_in = '0;
    logic audio_in_valid = 1'b0;
    logic audio_in_ready;
    logic out_tick = 1'b0;
    logic signed [15:0] interp_output;
    logic interp_output_valid, overrun, underrun;

    int compared = 0;
    int mismatched = 0;

    int H [16] = '{-300, -500, -400, 300, 1800, 3700, 5392, 6392,
                   6392, 5392, 3700, 1800, 300, -400, -500, -300};
    int dl [$];
    int m_phase;
    bit m_full;
    int m_buf;
    longint last_out;
    bit last_und;

    fir_interpolator #(
        .INT_FACTOR(4),
        .NUM_TAPS  (16),
        .COEF_WIDTH(16),
        .COEF_FRAC (15)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .audio_in           (audio_in),
        .audio_in_valid     (audio_in_valid),
        .audio_in_ready     (audio_in_ready),
        .out_tick           (out_tick),
        .interp_output      (interp_output),
        .interp_output_valid(interp_output_valid),
        .overrun            (overrun),
        .underrun           (underrun)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        dl = {};
        for (int k = 0; k < 16; k++) dl.push_back(0);
        m_phase = 0;
        m_full = 1'b0;
        m_buf = 0;
    endfunction

    // Filter output of the zero-stuffed stream: sum x*h, gain 4, round half up, clamp
    function automatic longint model_out();
        longint acc = 0;
        for (int k = 0; k < 16; k++) acc += longint'(dl[k]) * H[k];
        acc = (acc * 4 + 16384) >>> 15;
        return acc > 32767 ? 32767 : acc < -32768 ? -32768 : acc;
    endfunction

    function automatic longint model_shift(output bit und);
        int v = 0;
        und = 1'b0;
        if (m_phase == 0) begin
            if (m_full) begin
                v = m_buf;
                m_full = 1'b0;
            end else und = 1'b1;
        end
        m_phase = (m_phase + 1) % 4;
        dl.push_front(v);
        void'(dl.pop_back());
        return model_out();
    endfunction

    task automatic give(input int s);
        chk("ready_before_fill", audio_in_ready, 1);
        audio_in = 16'(s);
        audio_in_valid = 1'b1;
        step();
        audio_in_valid = 1'b0;
        m_full = 1'b1;
        m_buf = s;
        chk("ready_after_fill", audio_in_ready, 0);
    endtask

    // mode 0: no sample, 1: sample handed over before a phase-0 tick, 2: sample offered with the tick
    task automatic run_tick(input int s, input int mode, input int spacing);
        int lat;
        bit und, was_full;
        longint e;
        if (mode == 1 && m_phase == 0 && !m_full) give(s);
        was_full = m_full;
        e = model_shift(und);
        audio_in = 16'(s);
        audio_in_valid = (mode == 2);
        out_tick = 1'b1;
        step();
        out_tick = 1'b0;
        audio_in_valid = 1'b0;
        if (mode == 2 && !was_full) begin
            m_full = 1'b1;
            m_buf = s;
            chk("ready_after_tick_fill", audio_in_ready, 0);
        end
        lat = 1;
        last_und = underrun;
        chk("underrun", underrun, und);
        chk("overrun_idle", overrun, 0);
        while (!interp_output_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("latency", lat, 17);
        chk("output", interp_output, e);
        last_out = interp_output;
        step();
        lat++;
        chk("valid_width", interp_output_valid, 0);
        while (lat < spacing) begin
            step();
            lat++;
        end
    endtask

    initial begin
        longint e;
        bit und;
        int lat, nval, nov, s, mode;
        model_reset();
        repeat (2) step();
        chk("rst_ready", audio_in_ready, 1);
        chk("rst_valid", interp_output_valid, 0);
        chk("rst_output", interp_output, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_underrun", underrun, 0);
        rst_in = 1'b0;
        step();
        chk("idle_ready", audio_in_ready, 1);

        // impulse: outputs trace 2*h[k]
        for (int k = 0; k < 16; k++) begin
            run_tick(k == 0 ? 16384 : 0, 1, 20);
            chk("impulse", last_out, 2 * H[k]);
        end

        // DC: settles to 1000 on every phase
        for (int i = 0; i < 20; i++) begin
            run_tick(1000, 1, 20);
            if (i >= 16) chk("dc_settle", (last_out >= 999 && last_out <= 1001), 1);
        end

        // saturation at both rails, including the overshoot on the falling step
        for (int i = 0; i < 20; i++) run_tick(32767, 1, 20);
        chk("sat_pos", last_out, 32767);
        for (int i = 0; i < 20; i++) run_tick(-32768, 1, 20);
        chk("sat_neg", last_out, -32768);

        // overrun: early tick at T+10 (MAC) and at T+17 (OUT) are dropped
        e = model_shift(und);
        out_tick = 1'b1;
        step();
        out_tick = 1'b0;
        chk("ovr_first_underrun", underrun, und);
        lat = 1;
        nval = 0;
        nov = 0;
        while (lat < 40) begin
            if (lat == 10 || lat == 17) out_tick = 1'b1;
            step();
            lat++;
            out_tick = 1'b0;
            if (overrun) nov++;
            if (lat == 11) chk("overrun_early", overrun, 1);
            if (lat == 18) chk("overrun_in_out", overrun, 1);
            if (interp_output_valid) begin
                nval++;
                chk("ovr_latency", lat, 17);
                chk("ovr_output", interp_output, e);
            end
        end
        chk("overrun_count", nov, 2);
        chk("ovr_valid_count", nval, 1);

        // underrun: empty buffer at phase 0, phase sequence kept
        while (m_phase != 0) run_tick(0, 1, 20);
        run_tick(0, 0, 20);
        chk("underrun_seen", last_und, 1);
        for (int i = 0; i < 3; i++) run_tick(0, 0, 20);
        run_tick(1234, 1, 20);
        chk("underrun_clear", last_und, 0);

        // sample offered together with a phase-0 tick on an empty buffer
        while (m_phase != 0) run_tick(0, 0, 20);
        run_tick(700, 2, 20);
        chk("fill_with_tick_underrun", last_und, 1);
        for (int i = 0; i < 4; i++) run_tick(0, 0, 20);
        chk("fill_with_tick_used", last_und, 0);

        // random samples, rails and delivery modes
        for (int i = 0; i < 48; i++) begin
            s = $urandom_range(0, 2) == 0 ? ($urandom_range(0, 1) ? 32767 : -32768) : int'(shortint'($urandom));
            mode = $urandom_range(0, 9) == 0 ? 0 : ($urandom_range(0, 5) == 0 ? 2 : 1);
            run_tick(s, mode, 18 + int'($urandom_range(0, 3)));
        end

        // reset in the middle of a MAC
        out_tick = 1'b1;
        step();
        out_tick = 1'b0;
        repeat (4) step();
        rst_in = 1'b1;
        #1;
        chk("midrst_ready", audio_in_ready, 1);
        chk("midrst_valid", interp_output_valid, 0);
        chk("midrst_output", interp_output, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_underrun", underrun, 0);
        step();
        step();
        rst_in = 1'b0;
        nval = 0;
        repeat (30) begin
            step();
            if (interp_output_valid) nval++;
        end
        chk("post_reset_no_valid", nval, 0);
        model_reset();
        for (int k = 0; k < 16; k++) begin
            run_tick(k == 0 ? 16384 : 0, 1, 20);
            chk("post_reset_impulse", last_out, 2 * H[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
